pipe_tx_gen_ctrl: RTL

Transmit-side counterpart of the receive gen-control logic in the packet identifier. Reads 64-byte words from the TX packet buffer and slices each word into generation-dependent beats on the 16-lane PIPE TX bus: 16, 32 or 64 bytes per clock. Produces the per-byte valid mask for each beat, gated by link-up and PHY backpressure.

---
 rtl/pipe_tx_gen_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipe_tx_gen_ctrl.sv
// Slices 64-byte TX buffer words into gen-dependent PIPE beats (16/32/64 bytes) with byte-valid masks.
// Optional TX_BEAT_CNT_EN adds a 16-bit completed-beat counter output beat_cnt.
module pipe_tx_gen_ctrl #(
    parameter int GEN1_PIPEWIDTH = 8,
    parameter int GEN2_PIPEWIDTH = 16,
    parameter int GEN3_PIPEWIDTH = 32,
    parameter int GEN4_PIPEWIDTH = 8,
    parameter int GEN5_PIPEWIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         linkup,
    input  logic [2:0]   gen,
    input  logic         buf_empty,
    output logic         buf_rd_en,
    input  logic [511:0] buf_rd_data,
    input  logic [63:0]  buf_rd_mask,
    input  logic         tx_ready,
    output logic [511:0] tx_data,
    output logic [63:0]  tx_valid,
    output logic         busy,
    output logic         gen_err
`ifdef TX_BEAT_CNT_EN
    ,
    output logic [15:0]  beat_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_e;

    state_e         state_q, state_d;
    logic [511:0]   word_q, word_d;
    logic [63:0]    mask_q, mask_d;
    logic [1:0]     beat_q, beat_d;
    logic [2:0]     gen_q, gen_d;
    logic           gen_err_q;
    logic           rd_en;

    logic [6:0]     nbytes, off, off_next;
    logic [63:0]    byte_keep, mask_sh, next_sh;
    logic [511:0]   data_keep, word_sh;
    logic           can_rd, last_beat, next_empty, send;

    // Beat size in bytes is 16 lanes * W/8 = 2*W.
    function automatic logic [6:0] beat_bytes(input logic [2:0] g);
        case (g)
            3'd0:    return 7'(2 * GEN1_PIPEWIDTH);
            3'd1:    return 7'(2 * GEN2_PIPEWIDTH);
            3'd2:    return 7'(2 * GEN3_PIPEWIDTH);
            3'd3:    return 7'(2 * GEN4_PIPEWIDTH);
            3'd4:    return 7'(2 * GEN5_PIPEWIDTH);
            default: return 7'd16;
        endcase
    endfunction

    assign nbytes   = beat_bytes(gen_q);
    assign off      = 7'(beat_q) * nbytes;
    assign off_next = off + nbytes;

    for (genvar b = 0; b < 64; b++) begin : g_keep
        assign byte_keep[b]       = (7'(b) < nbytes);
        assign data_keep[8*b +: 8] = {8{byte_keep[b]}};
    end

    assign word_sh    = word_q >> {off, 3'b000};
    assign mask_sh    = mask_q >> off;
    assign next_sh    = mask_q >> off_next;
    assign last_beat  = (off_next >= 7'd64);
    assign next_empty = ((next_sh & byte_keep) == '0);
    assign can_rd     = linkup & ~buf_empty & (gen <= 3'd4);
    assign send       = (state_q == SEND);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mask_d  = mask_q;
        beat_d  = beat_q;
        gen_d   = gen_q;
        rd_en   = 1'b0;
        if (!linkup) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (can_rd) begin
                    rd_en   = 1'b1;
                    gen_d   = gen;
                    state_d = WAIT;
                end
                WAIT: begin
                    word_d  = buf_rd_data;
                    mask_d  = buf_rd_mask;
                    beat_d  = 2'd0;
                    state_d = (buf_rd_mask == '0) ? IDLE : SEND;
                end
                SEND: if (tx_ready) begin
                    if (last_beat || next_empty) begin
                        // Back-to-back words: next read overlaps the final beat.
                        if (can_rd) begin
                            rd_en   = 1'b1;
                            gen_d   = gen;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            mask_q    <= '0;
            beat_q    <= '0;
            gen_q     <= '0;
            gen_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            mask_q    <= mask_d;
            beat_q    <= beat_d;
            gen_q     <= gen_d;
            gen_err_q <= (gen > 3'd4);
        end
    end

    assign buf_rd_en = rd_en & ~rst;
    assign tx_data   = send ? (word_sh & data_keep) : '0;
    assign tx_valid  = (send && linkup) ? (mask_sh & byte_keep) : '0;
    assign busy      = (state_q != IDLE);
    assign gen_err   = gen_err_q;

`ifdef TX_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (!linkup)
            beat_cnt_d = '0;
        else if (send && tx_ready)
            beat_cnt_d = beat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat_cnt_q <= '0;
        else     beat_cnt_q <= beat_cnt_d;
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule
